// File: rtl/comp8bit_cascade_if.sv
// ============================================================================
// Module      : comp8bit_cascade_if
// Description : Operand, cascade-in and registered result bundle for
//               comp8bit_cascade. The err signal exists only when
//               COMP8_CASCADE_CHECK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface comp8bit_cascade_if;
   logic [7:0] a;
   logic [7:0] b;
   logic       gt;
   logic       lt;
   logic       eq;
   logic       agtb;
   logic       altb;
   logic       aeqb;
`ifdef COMP8_CASCADE_CHECK_EN
   logic       err;
`endif

   // master drives operands and cascade-in; slave is the comparator
`ifdef COMP8_CASCADE_CHECK_EN
   modport master (output a, b, gt, lt, eq, input agtb, altb, aeqb, err);
   modport slave  (input a, b, gt, lt, eq, output agtb, altb, aeqb, err);
`else
   modport master (output a, b, gt, lt, eq, input agtb, altb, aeqb);
   modport slave  (input a, b, gt, lt, eq, output agtb, altb, aeqb);
`endif
endinterface

`default_nettype wire

// File: rtl/comp8bit_cascade.sv
// ============================================================================
// Module      : comp8bit_cascade
// Description : 8-bit unsigned magnitude comparator with 7485-style cascade
//               inputs, built from two 4-bit slices, registered outputs.
//               Optional macro COMP8_CASCADE_CHECK_EN adds cascade checking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module comp8bit_cascade (
   input  wire               clk,
   input  wire               rst,
   comp8bit_cascade_if.slave bus
);

   // result vector ordering {gt, lt, eq}
   function automatic logic [2:0] slice4(
      input logic [3:0] x,
      input logic [3:0] y,
      input logic [2:0] ci
   );
      logic [2:0] res;
      if (x > y)
         res = 3'b100;
      else if (x < y)
         res = 3'b010;
      else
         res = ci;
      return res;
   endfunction

   logic [2:0] w_cas_in;
   logic [2:0] w_lo;
   logic [2:0] w_hi;
   logic [2:0] w_res;
   logic [2:0] r_res;

   assign w_cas_in = {bus.gt, bus.lt, bus.eq};
   assign w_lo     = slice4(bus.a[3:0], bus.b[3:0], w_cas_in);
   assign w_hi     = slice4(bus.a[7:4], bus.b[7:4], w_lo);

`ifdef COMP8_CASCADE_CHECK_EN
   logic w_err;
   logic w_equal;
   logic r_err;

   assign w_err   = (w_cas_in != 3'b100) && (w_cas_in != 3'b010) &&
                    (w_cas_in != 3'b001);
   assign w_equal = (bus.a == bus.b);
   // a malformed cascade must not leak through as a result on a tie
   assign w_res   = (w_err && w_equal) ? 3'b000 : w_hi;

   always_ff @(posedge clk) begin
      if (rst)
         r_err <= 1'b0;
      else
         r_err <= w_err;
   end

   assign bus.err = r_err;
`else
   assign w_res = w_hi;
`endif

   always_ff @(posedge clk) begin
      if (rst)
         r_res <= 3'b000;
      else
         r_res <= w_res;
   end

   assign bus.agtb = r_res[2];
   assign bus.altb = r_res[1];
   assign bus.aeqb = r_res[0];

endmodule

`default_nettype wire

// File: tb/tb_comp8bit_cascade.sv
// ============================================================================
// Module      : tb_comp8bit_cascade
// Description : Directed self-checking bench for comp8bit_cascade.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_comp8bit_cascade;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   comp8bit_cascade_if bus ();

   comp8bit_cascade dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%b expected=%b", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] cas);
      bus.a  = a;
      bus.b  = b;
      bus.gt = cas[2];
      bus.lt = cas[1];
      bus.eq = cas[0];
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] outs();
      return {bus.agtb, bus.altb, bus.aeqb};
   endfunction

   task automatic cmp(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] cas, input logic [2:0] exp);
      drive(a, b, cas);
      step();
      check(tag, {1'b0, outs()}, {1'b0, exp});
   endtask

   localparam logic [2:0] c_sa = 3'b001;

   initial begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic [2:0] model;
      errors = 0;
      checks = 0;

      // reset holds outputs low despite live operands
      rst = 1'b1;
      drive(8'h55, 8'h33, c_sa);
      step();
      check("reset_c1", {1'b0, outs()}, 4'b0000);
      step();
      check("reset_c2", {1'b0, outs()}, 4'b0000);
`ifdef COMP8_CASCADE_CHECK_EN
      check("reset_err", {3'b000, bus.err}, 4'b0000);
`endif
      rst = 1'b0;
      step();
      check("after_reset", {1'b0, outs()}, 4'b0100);

      cmp("std_36_129", 8'd36, 8'd129, c_sa, 3'b010);
      cmp("std_99_13",  8'd99, 8'd13,  c_sa, 3'b100);
      cmp("std_5_5",    8'd5,  8'd5,   c_sa, 3'b001);

      for (int i = 0; i < 8; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = (i == 3) ? ra : 8'($urandom_range(0, 255));
         model = (ra > rb) ? 3'b100 : (ra < rb) ? 3'b010 : 3'b001;
         cmp($sformatf("rand%0d", i), ra, rb, c_sa, model);
      end

      cmp("nib_10_0F", 8'h10, 8'h0F, c_sa, 3'b100);
      cmp("nib_0F_10", 8'h0F, 8'h10, c_sa, 3'b010);
      cmp("bnd_FF_00", 8'hFF, 8'h00, c_sa, 3'b100);
      cmp("bnd_00_FF", 8'h00, 8'hFF, c_sa, 3'b010);
      cmp("bnd_80_7F", 8'h80, 8'h7F, c_sa, 3'b100);
      cmp("bnd_00_00", 8'h00, 8'h00, c_sa, 3'b001);

      cmp("cas_pass_gt", 8'hA5, 8'hA5, 3'b100, 3'b100);
      cmp("cas_pass_lt", 8'hA5, 8'hA5, 3'b010, 3'b010);
      cmp("cas_ignored", 8'hA6, 8'hA5, 3'b010, 3'b100);

      // back-to-back, and output must hold until the next edge
      cmp("pipe_1_2", 8'd1, 8'd2, c_sa, 3'b010);
      drive(8'd2, 8'd1, c_sa);
      #1;
      check("pipe_hold", {1'b0, outs()}, 4'b0010);
      step();
      check("pipe_2_1", {1'b0, outs()}, 4'b0100);
      cmp("pipe_3_3", 8'd3, 8'd3, c_sa, 3'b001);

      // mid-stream reset discards the in-flight result
      drive(8'hC0, 8'h01, c_sa);
      rst = 1'b1;
      step();
      check("mid_reset", {1'b0, outs()}, 4'b0000);
      rst = 1'b0;
      step();
      check("post_mid_reset", {1'b0, outs()}, 4'b0100);

`ifdef COMP8_CASCADE_CHECK_EN
      cmp("chk_tie_bad", 8'h3C, 8'h3C, 3'b110, 3'b000);
      check("chk_err_tie", {3'b000, bus.err}, 4'b0001);
      cmp("chk_gt_bad", 8'h3D, 8'h3C, 3'b110, 3'b100);
      check("chk_err_gt", {3'b000, bus.err}, 4'b0001);
      cmp("chk_ok", 8'h3C, 8'h3C, 3'b001, 3'b001);
      check("chk_err_ok", {3'b000, bus.err}, 4'b0000);
`else
      cmp("raw_nonhot", 8'h3C, 8'h3C, 3'b110, 3'b110);
      cmp("raw_zero",   8'h3C, 8'h3C, 3'b000, 3'b000);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
